seq_normalizer: RTL
===================

# seq_normalizer

Multi-cycle normalizer: the inverse of the shift-by-amount datapath. Given a word, it shifts it one bit per cycle until the selected end bit is 1, then reports the normalized word and the shift amount that produced it. `lr=1` normalizes toward the MSB (counts leading zeros); `lr=0` normalizes toward the LSB (counts trailing zeros). Its `amt` output is the shift amount that the combinational left/right barrel shifters need to reproduce the same result.

## Interface
- `N`, default 8, data width, ≥ 2.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready=1`.
- `a`  in  N  word to normalize; sampled on the accepting edge.
- `lr`  in  1  direction; 1 = toward MSB (left), 0 = toward LSB (right); sampled with `a`.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; result valid.
- `y`  out  N  normalized word.
- `amt`  out  $clog2(N)  number of single-bit shifts applied.
- `zero`  out  1  input was all zeros.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `ready=1`. On `start`:
  - Load the data register with `a` and latch `lr`.
  - Clear the count and `zero`.
  - If `a==0`: set `zero=1` and go to DONE.
  - Otherwise go to SHIFT.
- `start` while not IDLE: ignored; inputs not sampled.
- SHIFT: test the target bit (`y[N-1]` if `lr`, else `y[0]`).
  - Target bit 1: go to DONE; register unchanged.
  - Target bit 0: shift one bit toward the target, zero fill, increment count, stay in SHIFT.
- A nonzero input needs at most N-1 shifts, so the count never wraps. `amt` equals the leading-zero count (`lr=1`) or trailing-zero count (`lr=0`).
- DONE: `done=1` for exactly one cycle, then IDLE unconditionally.
- Outputs `y`, `amt` and `zero` are the register contents at all times.
  - They are stable from DONE until the next accepted `start`.
  - `amt` is 0 and `y=0` when `zero=1`.
- Reset: state IDLE; `y=0`, `amt=0`, `zero=0`, `done=0`, `ready=1`. Reset mid-operation aborts with no `done`. Reset wins over a simultaneous `start`.

## Timing
- Accepting edge is cycle 0. Let k = zero count in the selected direction.
- Nonzero input:
  - SHIFT occupies cycles 1..k+1.
  - `done` is high in cycle k+2.
  - `ready` is high again in cycle k+3.
- Zero input: `done` in cycle 1, `ready` in cycle 2.
- Throughput: a new `start` is accepted in the first IDLE cycle after `done`. There is no back-to-back overlap with `done`.
- No combinational path from inputs to outputs.

## Structure
- Package `normalizer_pkg`: `state_t` enum {IDLE, SHIFT, DONE}.
- Sub-module `norm_step #(N)`: combinational one-bit shift.
  - Inputs `d` and `lr`; output `q`.
  - `lr=1` gives `q = d<<1`; `lr=0` gives `q = d>>1`.
- Top level holds the FSM, data register, count, and the `zero` flag.

## Test plan
- N=8, `a=8'b0001_0110`, `lr=1` → `y=8'b1011_0000`, `amt=3`, `zero=0`, `done` in cycle 5.
- Same `a`, `lr=0` → `y=8'b0000_1011`, `amt=1`, `done` in cycle 3.
- Boundary values:
  - `a=8'h80`, `lr=1` → `amt=0`, `done` in cycle 2.
  - `a=8'h01`, `lr=1` → `y=8'h80`, `amt=7`, `done` in cycle 9.
  - `a=8'h80`, `lr=0` → `y=8'h01`, `amt=7`.
- `a=8'h00`, either `lr` → `zero=1`, `y=0`, `amt=0`, `done` in cycle 1.
- Busy and reset:
  - `start` with `a=8'hFF` during SHIFT of `8'h01` is ignored. Result is `amt=7`, with exactly one `done`.
  - `reset` in cycle 3 of that run → no `done`; outputs zeroed; `ready=1` next cycle.
- Randomized: check `amt` against the reference leading/trailing-zero count. Check that the barrel-shifted input equals `y`.

Source files
------------

// File: rtl/normalizer_pkg.sv
// Shared types for the sequential normalizer: controller state encoding.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/norm_step.sv
// One-bit zero-fill shift toward the MSB (lr=1) or the LSB (lr=0).
module norm_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] d,
  input  logic         lr,
  output logic [N-1:0] q
);

  // single-position shift, zero filled
  always_comb begin
    q = d;
    if (lr) begin
      q = d << 1;
    end else begin
      q = d >> 1;
    end
  end

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts a word one bit per cycle until the chosen end
// bit is set, reporting the normalized word, the shift count and a zero flag.
module seq_normalizer
  import normalizer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         a,
  input  logic                 lr,
  output logic                 ready,
  output logic                 done,
  output logic [N-1:0]         y,
  output logic [$clog2(N)-1:0] amt,
  output logic                 zero
);

  localparam int AW = $clog2(N);

  state_t        state_r;
  state_t        state_s;
  logic [N-1:0]  y_r;
  logic [N-1:0]  step_s;
  logic [AW-1:0] amt_r;
  logic          zero_r;
  logic          lr_r;
  logic          tbit_s;

  norm_step #(.N(N)) u_step (
    .d  (y_r),
    .lr (lr_r),
    .q  (step_s)
  );

  // target bit of the current word in the latched direction
  always_comb begin
    tbit_s = 1'b0;
    if (lr_r) begin
      tbit_s = y_r[N-1];
    end else begin
      tbit_s = y_r[0];
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (a == '0) ? DONE : SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (tbit_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, data register, shift count and zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      y_r     <= '0;
      amt_r   <= '0;
      zero_r  <= 1'b0;
      lr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            y_r    <= a;
            lr_r   <= lr;
            amt_r  <= '0;
            zero_r <= (a == '0);
          end
        end
        SHIFT: begin
          // a nonzero word reaches its target within N-1 steps, so amt never wraps
          if (!tbit_s) begin
            y_r   <= step_s;
            amt_r <= amt_r + AW'(1);
          end
        end
        DONE: begin
          y_r <= y_r;
        end
        default: begin
          y_r <= y_r;
        end
      endcase
    end
  end

  assign ready = (state_r == IDLE);
  assign done  = (state_r == DONE);
  assign y     = y_r;
  assign amt   = amt_r;
  assign zero  = zero_r;

endmodule
